sram_bus_arbiter: RTL and testbench

- Two-master arbiter directly upstream of sram_controller.
- Merges the CPU instruction-fetch port (read-only) and data port (read/write, byte mask) onto the single controller bus (read_op, write_op, bus_addr, bus_data_write, byte_mask, bus_data_read, bus_stall).
- Owns request latching, priority with anti-starvation, per-master stall generation and a stuck-controller watchdog.

---
 rtl/sram_bus_arbiter_if.sv | 46 ++++
 rtl/sram_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_bus_arbiter_if.sv
// sram_bus_arbiter_if
//   Bundles every signal that crosses the arbiter boundary except clock and reset.
//   CPU instruction-fetch port: i_req, i_addr, i_rdata, i_stall
//   CPU data port:              d_req, d_we, d_addr, d_wdata, d_mask, d_rdata, d_stall
//   Controller bus:             read_op, write_op, bus_addr, bus_data_write, byte_mask,
//                               bus_data_read, bus_stall
//   Status:                     timeout_err, grant_dbg
//   modport slave  - the arbiter itself (serves the two CPU masters, drives the controller)
//   modport master - the environment: both CPU masters plus the SRAM controller
interface sram_bus_arbiter_if;
  logic        i_req;
  logic [19:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_stall;

  logic        d_req;
  logic        d_we;
  logic [19:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_mask;
  logic [31:0] d_rdata;
  logic        d_stall;

  logic        read_op;
  logic        write_op;
  logic [19:0] bus_addr;
  logic [31:0] bus_data_write;
  logic [3:0]  byte_mask;
  logic [31:0] bus_data_read;
  logic        bus_stall;

  logic        timeout_err;
  logic [1:0]  grant_dbg;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_mask, bus_data_read, bus_stall,
    output i_rdata, i_stall, d_rdata, d_stall, read_op, write_op, bus_addr, bus_data_write,
           byte_mask, timeout_err, grant_dbg
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_mask, bus_data_read, bus_stall,
    input  i_rdata, i_stall, d_rdata, d_stall, read_op, write_op, bus_addr, bus_data_write,
           byte_mask, timeout_err, grant_dbg
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
//   Two-master arbiter sitting directly in front of the SRAM controller. The data port
//   normally wins contention, but after STREAK_MAX consecutive data grants taken while an
//   instruction fetch was waiting, the fetch port is served. Every transaction is followed
//   by one idle cycle before the next grant. A watchdog raises a sticky timeout_err when a
//   granted operation stays stalled for TIMEOUT_CYCLES cycles (the operation is not aborted).
//   Ports:
//     clk    - system clock, rising edge
//     rst_n  - asynchronous active-low reset
//     bus    - sram_bus_arbiter_if.slave: both CPU ports, the controller bus and status
module sram_bus_arbiter #(
  parameter int STREAK_MAX     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_bus_arbiter_if.slave bus
);

  localparam int                WDOG_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]        STREAK_LIM = 4'(STREAK_MAX);
  localparam logic [WDOG_W-1:0] WDOG_LIM   = WDOG_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic              read_op_q, read_op_d;
  logic              write_op_q, write_op_d;
  logic [19:0]       bus_addr_q, bus_addr_d;
  logic [31:0]       bus_data_write_q, bus_data_write_d;
  logic [3:0]        byte_mask_q, byte_mask_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic [3:0]        streak_q, streak_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              timeout_err_q, timeout_err_d;

  logic complete;
  logic data_wins;

  // An op is always asserted while granted, so completion is simply "granted and not stalled".
  assign complete  = (state_q != IDLE) && !bus.bus_stall;
  // Data has priority unless the fetch port has already been passed over STREAK_MAX times.
  assign data_wins = bus.d_req && !(bus.i_req && (streak_q == STREAK_LIM));

  always_comb begin
    state_d          = state_q;
    read_op_d        = read_op_q;
    write_op_d       = write_op_q;
    bus_addr_d       = bus_addr_q;
    bus_data_write_d = bus_data_write_q;
    byte_mask_d      = byte_mask_q;
    i_rdata_d        = i_rdata_q;
    d_rdata_d        = d_rdata_q;
    streak_d         = streak_q;
    wdog_d           = wdog_q;
    timeout_err_d    = timeout_err_q;

    unique case (state_q)
      IDLE: begin
        if (data_wins) begin
          state_d          = GNT_D;
          read_op_d        = !bus.d_we;
          write_op_d       = bus.d_we;
          bus_addr_d       = bus.d_addr;
          bus_data_write_d = bus.d_wdata;
          byte_mask_d      = bus.d_mask;
          // data_wins guarantees streak_q < STREAK_LIM when i_req is high, so +1 cannot overshoot.
          streak_d         = bus.i_req ? (streak_q + 4'd1) : 4'd0;
        end else if (bus.i_req) begin
          state_d          = GNT_I;
          read_op_d        = 1'b1;
          write_op_d       = 1'b0;
          bus_addr_d       = bus.i_addr;
          bus_data_write_d = 32'd0;
          byte_mask_d      = 4'b1111;
          streak_d         = 4'd0;
        end
      end
      GNT_I, GNT_D: begin
        if (complete) begin
          if (state_q == GNT_I) begin
            i_rdata_d = bus.bus_data_read;
          end else if (read_op_q) begin
            d_rdata_d = bus.bus_data_read;
          end
          state_d    = IDLE;
          read_op_d  = 1'b0;
          write_op_d = 1'b0;
          wdog_d     = '0;
        end else if (wdog_q != WDOG_LIM) begin
          // Counter saturates at the limit; the flag is sticky until reset.
          wdog_d = wdog_q + WDOG_W'(1);
          if (wdog_d == WDOG_LIM) begin
            timeout_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      read_op_q        <= 1'b0;
      write_op_q       <= 1'b0;
      bus_addr_q       <= 20'd0;
      bus_data_write_q <= 32'd0;
      byte_mask_q      <= 4'd0;
      i_rdata_q        <= 32'd0;
      d_rdata_q        <= 32'd0;
      streak_q         <= 4'd0;
      wdog_q           <= '0;
      timeout_err_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      read_op_q        <= read_op_d;
      write_op_q       <= write_op_d;
      bus_addr_q       <= bus_addr_d;
      bus_data_write_q <= bus_data_write_d;
      byte_mask_q      <= byte_mask_d;
      i_rdata_q        <= i_rdata_d;
      d_rdata_q        <= d_rdata_d;
      streak_q         <= streak_d;
      wdog_q           <= wdog_d;
      timeout_err_q    <= timeout_err_d;
    end
  end

  assign bus.read_op        = read_op_q;
  assign bus.write_op       = write_op_q;
  assign bus.bus_addr       = bus_addr_q;
  assign bus.bus_data_write = bus_data_write_q;
  assign bus.byte_mask      = byte_mask_q;
  assign bus.timeout_err    = timeout_err_q;
  assign bus.grant_dbg      = (state_q == GNT_I) ? 2'b01 :
                              (state_q == GNT_D) ? 2'b10 : 2'b00;

  // A requester is released only in its own completion cycle.
  assign bus.i_stall = bus.i_req && !((state_q == GNT_I) && complete);
  assign bus.d_stall = bus.d_req && !((state_q == GNT_D) && complete);

  // Read data is forwarded in the completion cycle so the master can use it without waiting.
  assign bus.i_rdata = ((state_q == GNT_I) && complete) ? bus.bus_data_read : i_rdata_q;
  assign bus.d_rdata = ((state_q == GNT_D) && complete && read_op_q) ? bus.bus_data_read
                                                                      : d_rdata_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter
//   Directed scenarios for reset, writes, reads, contention, watchdog and zero-wait
//   behaviour, followed by a randomized run checked against a transaction-level model.
module tb_sram_bus_arbiter;

  localparam int STREAK_MAX     = 4;
  localparam int TIMEOUT_CYCLES = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors     = 0;
  int   miscompares = 0;

  sram_bus_arbiter_if bus_if();

  sram_bus_arbiter #(
    .STREAK_MAX     (STREAK_MAX),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic drive_idle();
    bus_if.i_req         = 1'b0;
    bus_if.i_addr        = 20'd0;
    bus_if.d_req         = 1'b0;
    bus_if.d_we          = 1'b0;
    bus_if.d_addr        = 20'd0;
    bus_if.d_wdata       = 32'd0;
    bus_if.d_mask        = 4'd0;
    bus_if.bus_data_read = 32'd0;
    bus_if.bus_stall     = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    bus_if.bus_data_read = 32'hFFFFFFFF;
    #1;
    vectors++; if (bus_if.read_op !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_read_op: got %b expected 0", bus_if.read_op); end
    vectors++; if (bus_if.write_op !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_write_op: got %b expected 0", bus_if.write_op); end
    vectors++; if (bus_if.i_rdata !== 32'd0) begin miscompares++; $display("[TB] FAIL rst_i_rdata: got %h expected 0", bus_if.i_rdata); end
    vectors++; if (bus_if.grant_dbg !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_grant: got %b expected 00", bus_if.grant_dbg); end
    vectors++; if (bus_if.timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_timeout: got %b expected 0", bus_if.timeout_err); end

    // Start a stalled data write, then pull reset in the middle of the grant.
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.bus_data_read = 32'd0;
    bus_if.d_req = 1'b1; bus_if.d_we = 1'b1; bus_if.d_addr = 20'h00ABC;
    bus_if.d_wdata = 32'hDEADBEEF; bus_if.d_mask = 4'hF; bus_if.bus_stall = 1'b1;
    @(negedge clk); #1;
    vectors++; if (bus_if.write_op !== 1'b1) begin miscompares++; $display("[TB] FAIL pre_rst_write_op: got %b expected 1", bus_if.write_op); end
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (bus_if.write_op !== 1'b0) begin miscompares++; $display("[TB] FAIL async_write_op: got %b expected 0", bus_if.write_op); end
    vectors++; if (bus_if.bus_addr !== 20'd0) begin miscompares++; $display("[TB] FAIL async_bus_addr: got %h expected 0", bus_if.bus_addr); end
    vectors++; if (bus_if.bus_data_write !== 32'd0) begin miscompares++; $display("[TB] FAIL async_wdata: got %h expected 0", bus_if.bus_data_write); end
    vectors++; if (bus_if.byte_mask !== 4'd0) begin miscompares++; $display("[TB] FAIL async_mask: got %h expected 0", bus_if.byte_mask); end
    vectors++; if (bus_if.d_rdata !== 32'd0) begin miscompares++; $display("[TB] FAIL async_d_rdata: got %h expected 0", bus_if.d_rdata); end
    vectors++; if (bus_if.grant_dbg !== 2'b00) begin miscompares++; $display("[TB] FAIL async_grant: got %b expected 00", bus_if.grant_dbg); end
    drive_idle();

    // First request after release is on the bus one cycle later.
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.i_req = 1'b1; bus_if.i_addr = 20'h00010;
    @(negedge clk); #1;
    vectors++; if (bus_if.read_op !== 1'b1) begin miscompares++; $display("[TB] FAIL post_rst_read_op: got %b expected 1", bus_if.read_op); end
    vectors++; if (bus_if.bus_addr !== 20'h00010) begin miscompares++; $display("[TB] FAIL post_rst_addr: got %h expected 00010", bus_if.bus_addr); end
    vectors++; if (bus_if.byte_mask !== 4'hF) begin miscompares++; $display("[TB] FAIL post_rst_mask: got %h expected f", bus_if.byte_mask); end
    vectors++; if (bus_if.grant_dbg !== 2'b01) begin miscompares++; $display("[TB] FAIL post_rst_grant: got %b expected 01", bus_if.grant_dbg); end
    vectors++; if (bus_if.i_stall !== 1'b0) begin miscompares++; $display("[TB] FAIL post_rst_i_stall: got %b expected 0", bus_if.i_stall); end
    @(negedge clk);
    bus_if.i_req = 1'b0;
    #1;
    vectors++; if (bus_if.read_op !== 1'b0) begin miscompares++; $display("[TB] FAIL post_rst_op_clear: got %b expected 0", bus_if.read_op); end
  endtask

  task automatic test_data_write();
    @(negedge clk);
    bus_if.d_req = 1'b1; bus_if.d_we = 1'b1; bus_if.d_addr = 20'h00004;
    bus_if.d_wdata = 32'h0000FFFF; bus_if.d_mask = 4'b0011;
    bus_if.i_req = 1'b1; bus_if.i_addr = 20'h00020;
    bus_if.bus_stall = 1'b1; bus_if.bus_data_read = 32'hCAFEF00D;
    #1;
    vectors++; if (bus_if.write_op !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_latency: got %b expected 0", bus_if.write_op); end
    vectors++; if (bus_if.d_stall !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_idle_d_stall: got %b expected 1", bus_if.d_stall); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus_if.bus_stall = (k < 4);
      #1;
      vectors++; if (bus_if.write_op !== 1'b1 || bus_if.read_op !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_ops[%0d]: got w=%b r=%b expected w=1 r=0", k, bus_if.write_op, bus_if.read_op); end
      vectors++; if (bus_if.byte_mask !== 4'b0011) begin miscompares++; $display("[TB] FAIL wr_mask[%0d]: got %b expected 0011", k, bus_if.byte_mask); end
      vectors++; if (bus_if.bus_addr !== 20'h00004 || bus_if.bus_data_write !== 32'h0000FFFF) begin miscompares++; $display("[TB] FAIL wr_fields[%0d]: got %h/%h expected 00004/0000ffff", k, bus_if.bus_addr, bus_if.bus_data_write); end
      vectors++; if (bus_if.d_stall !== (k < 4)) begin miscompares++; $display("[TB] FAIL wr_d_stall[%0d]: got %b expected %b", k, bus_if.d_stall, (k < 4)); end
      vectors++; if (bus_if.i_stall !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_i_stall[%0d]: got %b expected 1", k, bus_if.i_stall); end
    end
    vectors++; if (bus_if.d_rdata !== 32'd0) begin miscompares++; $display("[TB] FAIL wr_no_forward: got %h expected 0", bus_if.d_rdata); end

    // Turnaround cycle, then the waiting fetch is served.
    @(negedge clk);
    bus_if.d_req = 1'b0; bus_if.bus_stall = 1'b0;
    #1;
    vectors++; if (bus_if.write_op !== 1'b0 || bus_if.read_op !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_turnaround: got w=%b r=%b expected 0 0", bus_if.write_op, bus_if.read_op); end
    vectors++; if (bus_if.i_stall !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_turn_i_stall: got %b expected 1", bus_if.i_stall); end
    vectors++; if (bus_if.d_rdata !== 32'd0) begin miscompares++; $display("[TB] FAIL wr_d_rdata_kept: got %h expected 0", bus_if.d_rdata); end
    @(negedge clk); #1;
    vectors++; if (bus_if.read_op !== 1'b1 || bus_if.bus_addr !== 20'h00020) begin miscompares++; $display("[TB] FAIL wr_then_inst: got r=%b addr=%h expected 1/00020", bus_if.read_op, bus_if.bus_addr); end
    vectors++; if (bus_if.i_rdata !== 32'hCAFEF00D) begin miscompares++; $display("[TB] FAIL wr_then_inst_fwd: got %h expected cafef00d", bus_if.i_rdata); end
    @(negedge clk);
    bus_if.i_req = 1'b0;
  endtask

  task automatic test_reads();
    @(negedge clk);
    bus_if.i_req = 1'b1; bus_if.i_addr = 20'h00100;
    bus_if.bus_stall = 1'b1; bus_if.bus_data_read = 32'h0;
    @(negedge clk); #1;
    vectors++; if (bus_if.i_rdata !== 32'hCAFEF00D) begin miscompares++; $display("[TB] FAIL rd_stalled_hold: got %h expected cafef00d", bus_if.i_rdata); end
    @(negedge clk);
    bus_if.bus_stall = 1'b0; bus_if.bus_data_read = 32'h12345678;
    #1;
    vectors++; if (bus_if.i_rdata !== 32'h12345678) begin miscompares++; $display("[TB] FAIL rd_i_forward: got %h expected 12345678", bus_if.i_rdata); end
    vectors++; if (bus_if.d_rdata !== 32'd0) begin miscompares++; $display("[TB] FAIL rd_d_untouched: got %h expected 0", bus_if.d_rdata); end
    @(negedge clk);
    bus_if.i_req = 1'b0; bus_if.bus_data_read = 32'h0BADBEEF;
    #1;
    vectors++; if (bus_if.i_rdata !== 32'h12345678) begin miscompares++; $display("[TB] FAIL rd_i_held: got %h expected 12345678", bus_if.i_rdata); end
    vectors++; if (bus_if.d_rdata !== 32'd0) begin miscompares++; $display("[TB] FAIL rd_d_held: got %h expected 0", bus_if.d_rdata); end

    @(negedge clk);
    bus_if.d_req = 1'b1; bus_if.d_we = 1'b0; bus_if.d_addr = 20'h00200; bus_if.d_mask = 4'b0101;
    bus_if.bus_data_read = 32'hA5A55A5A;
    @(negedge clk); #1;
    vectors++; if (bus_if.read_op !== 1'b1 || bus_if.write_op !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_d_ops: got r=%b w=%b expected 1 0", bus_if.read_op, bus_if.write_op); end
    vectors++; if (bus_if.byte_mask !== 4'b0101) begin miscompares++; $display("[TB] FAIL rd_d_mask: got %b expected 0101", bus_if.byte_mask); end
    vectors++; if (bus_if.d_rdata !== 32'hA5A55A5A) begin miscompares++; $display("[TB] FAIL rd_d_forward: got %h expected a5a55a5a", bus_if.d_rdata); end
    @(negedge clk);
    bus_if.d_req = 1'b0; bus_if.bus_data_read = 32'd0;
    #1;
    vectors++; if (bus_if.d_rdata !== 32'hA5A55A5A) begin miscompares++; $display("[TB] FAIL rd_d_held2: got %h expected a5a55a5a", bus_if.d_rdata); end
    vectors++; if (bus_if.i_rdata !== 32'h12345678) begin miscompares++; $display("[TB] FAIL rd_i_untouched: got %h expected 12345678", bus_if.i_rdata); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_gnt;
    apply_reset();
    @(negedge clk);
    bus_if.i_req = 1'b1; bus_if.i_addr = 20'h11111;
    bus_if.d_req = 1'b1; bus_if.d_we = 1'b1; bus_if.d_addr = 20'h22222; bus_if.d_mask = 4'hF;
    for (int g = 0; g < 10; g++) begin
      // Every (STREAK_MAX+1)-th grant belongs to the fetch port.
      exp_gnt = ((g % (STREAK_MAX + 1)) == STREAK_MAX) ? 2'b01 : 2'b10;
      @(negedge clk); #1;
      vectors++; if (bus_if.grant_dbg !== exp_gnt) begin miscompares++; $display("[TB] FAIL cont_grant[%0d]: got %b expected %b", g, bus_if.grant_dbg, exp_gnt); end
      vectors++; if (bus_if.read_op !== (exp_gnt == 2'b01) || bus_if.write_op !== (exp_gnt == 2'b10)) begin miscompares++; $display("[TB] FAIL cont_ops[%0d]: got r=%b w=%b", g, bus_if.read_op, bus_if.write_op); end
      @(negedge clk); #1;
      vectors++; if (bus_if.grant_dbg !== 2'b00 || bus_if.read_op !== 1'b0 || bus_if.write_op !== 1'b0) begin miscompares++; $display("[TB] FAIL cont_gap[%0d]: got g=%b r=%b w=%b expected idle", g, bus_if.grant_dbg, bus_if.read_op, bus_if.write_op); end
      if (g == 9) bus_if.i_req = 1'b0;
    end
    @(negedge clk); #1;
    vectors++; if (bus_if.grant_dbg !== 2'b10) begin miscompares++; $display("[TB] FAIL cont_tail: got %b expected 10", bus_if.grant_dbg); end
    @(negedge clk);
    bus_if.d_req = 1'b0;
  endtask

  task automatic test_watchdog();
    apply_reset();
    @(negedge clk);
    bus_if.d_req = 1'b1; bus_if.d_we = 1'b1; bus_if.d_addr = 20'h00300; bus_if.bus_stall = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk); #1;
      vectors++; if (bus_if.timeout_err !== (k > TIMEOUT_CYCLES)) begin miscompares++; $display("[TB] FAIL wdog_err[%0d]: got %b expected %b", k, bus_if.timeout_err, (k > TIMEOUT_CYCLES)); end
      vectors++; if (bus_if.write_op !== 1'b1) begin miscompares++; $display("[TB] FAIL wdog_no_abort[%0d]: got %b expected 1", k, bus_if.write_op); end
    end
    @(negedge clk);
    bus_if.bus_stall = 1'b0;
    #1;
    vectors++; if (bus_if.d_stall !== 1'b0) begin miscompares++; $display("[TB] FAIL wdog_complete: got %b expected 0", bus_if.d_stall); end
    @(negedge clk);
    bus_if.d_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++; if (bus_if.timeout_err !== 1'b1) begin miscompares++; $display("[TB] FAIL wdog_sticky[%0d]: got %b expected 1", k, bus_if.timeout_err); end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    vectors++; if (bus_if.timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL wdog_reset: got %b expected 0", bus_if.timeout_err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero_wait();
    apply_reset();
    @(negedge clk);
    bus_if.d_req = 1'b1; bus_if.d_we = 1'b0; bus_if.d_addr = 20'h00400;
    bus_if.bus_stall = 1'b0; bus_if.bus_data_read = 32'h55AA00FF;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk); #1;
      vectors++; if (bus_if.read_op !== (c % 2 == 1)) begin miscompares++; $display("[TB] FAIL zw_op[%0d]: got %b expected %b", c, bus_if.read_op, (c % 2 == 1)); end
      vectors++; if (bus_if.d_stall !== (c % 2 == 0)) begin miscompares++; $display("[TB] FAIL zw_stall[%0d]: got %b expected %b", c, bus_if.d_stall, (c % 2 == 0)); end
    end
    @(negedge clk);
    bus_if.d_req = 1'b0;
  endtask

  // Transaction-level reference: tracks who owns the bus, which fields were latched, the
  // number of data grants in a row that passed over a waiting fetch, and stalled cycles.
  task automatic test_random();
    int          owner = 0;
    int          streak = 0;
    int          stall_cnt = 0;
    bit          err = 0;
    bit          i_pend = 0;
    bit          d_pend = 0;
    bit          exp_we = 0;
    bit          done;
    logic [19:0] exp_addr = '0;
    logic [31:0] exp_wdata = '0;
    logic [3:0]  exp_mask = '0;
    logic [31:0] exp_irdata = '0;
    logic [31:0] exp_drdata = '0;
    logic [31:0] exp_ir, exp_dr;
    logic [1:0]  exp_gnt;
    logic        exp_rd, exp_wr, exp_is, exp_ds;
    apply_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (!i_pend) begin
        bus_if.i_req = 1'b0;
        if ($urandom_range(0, 2) == 0) begin
          i_pend = 1; bus_if.i_req = 1'b1; bus_if.i_addr = 20'($urandom);
        end
      end
      if (!d_pend) begin
        bus_if.d_req = 1'b0;
        if ($urandom_range(0, 2) != 0) begin
          d_pend = 1; bus_if.d_req = 1'b1; bus_if.d_we = 1'($urandom_range(0, 1));
          bus_if.d_addr = 20'($urandom); bus_if.d_wdata = $urandom; bus_if.d_mask = 4'($urandom);
        end
      end
      bus_if.bus_stall     = ($urandom_range(0, 99) < ((cyc < 200) ? 30 : 85));
      bus_if.bus_data_read = $urandom;
      #1;
      done    = (owner != 0) && !bus_if.bus_stall;
      exp_gnt = 2'(owner);
      exp_rd  = (owner == 1) || (owner == 2 && !exp_we);
      exp_wr  = (owner == 2) && exp_we;
      exp_is  = bus_if.i_req && !(owner == 1 && done);
      exp_ds  = bus_if.d_req && !(owner == 2 && done);
      exp_ir  = (owner == 1 && done) ? bus_if.bus_data_read : exp_irdata;
      exp_dr  = (owner == 2 && done && !exp_we) ? bus_if.bus_data_read : exp_drdata;
      vectors++; if (bus_if.grant_dbg !== exp_gnt) begin miscompares++; $display("[TB] FAIL rnd_grant@%0d: got %b expected %b", cyc, bus_if.grant_dbg, exp_gnt); end
      vectors++; if (bus_if.read_op !== exp_rd || bus_if.write_op !== exp_wr) begin miscompares++; $display("[TB] FAIL rnd_ops@%0d: got r=%b w=%b expected r=%b w=%b", cyc, bus_if.read_op, bus_if.write_op, exp_rd, exp_wr); end
      if (owner != 0) begin
        vectors++; if (bus_if.bus_addr !== exp_addr || bus_if.bus_data_write !== exp_wdata || bus_if.byte_mask !== exp_mask) begin miscompares++; $display("[TB] FAIL rnd_fields@%0d: got %h/%h/%h expected %h/%h/%h", cyc, bus_if.bus_addr, bus_if.bus_data_write, bus_if.byte_mask, exp_addr, exp_wdata, exp_mask); end
      end
      vectors++; if (bus_if.i_stall !== exp_is || bus_if.d_stall !== exp_ds) begin miscompares++; $display("[TB] FAIL rnd_stalls@%0d: got i=%b d=%b expected i=%b d=%b", cyc, bus_if.i_stall, bus_if.d_stall, exp_is, exp_ds); end
      vectors++; if (bus_if.i_rdata !== exp_ir || bus_if.d_rdata !== exp_dr) begin miscompares++; $display("[TB] FAIL rnd_rdata@%0d: got %h/%h expected %h/%h", cyc, bus_if.i_rdata, bus_if.d_rdata, exp_ir, exp_dr); end
      vectors++; if (bus_if.timeout_err !== err) begin miscompares++; $display("[TB] FAIL rnd_timeout@%0d: got %b expected %b", cyc, bus_if.timeout_err, err); end

      // Advance the model across the coming rising edge.
      if (owner != 0) begin
        if (done) begin
          if (owner == 1) begin
            exp_irdata = bus_if.bus_data_read; i_pend = 0;
          end else begin
            if (!exp_we) exp_drdata = bus_if.bus_data_read;
            d_pend = 0;
          end
          owner = 0; stall_cnt = 0;
        end else begin
          stall_cnt++;
          if (stall_cnt >= TIMEOUT_CYCLES) err = 1;
        end
      end else if (bus_if.d_req && (!bus_if.i_req || streak < STREAK_MAX)) begin
        owner = 2; exp_we = bus_if.d_we; exp_addr = bus_if.d_addr;
        exp_wdata = bus_if.d_wdata; exp_mask = bus_if.d_mask;
        streak = bus_if.i_req ? streak + 1 : 0;
      end else if (bus_if.i_req) begin
        owner = 1; exp_we = 0; exp_addr = bus_if.i_addr;
        exp_wdata = 32'd0; exp_mask = 4'hF; streak = 0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    test_reset();
    test_data_write();
    test_reads();
    test_contention();
    test_watchdog();
    test_zero_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
